step_counter_ctrl: RTL and testbench
====================================

# step_counter_ctrl

Run-controlled 3-bit step counter that sits directly upstream of the team's 3-bit ripple adder. It drives the adder's operands (current count, programmable step), consumes the sum and carry-out, and registers the result, with terminal-value detection, pause/resume, run bookkeeping and carry handling. Typical use is programmable-stride count sequences in the counter designs.

## Interface
- INIT, 3'd0, count value loaded on reset, clear and every run start
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear, highest priority after reset
- start  in  1  begin a run (honoured in IDLE and DONE only)
- pause  in  1  level; holds count while high during a run
- step  in  3  increment applied per active cycle (adder B operand)
- limit  in  3  terminal value
- count  out  3  registered count (adder A operand)
- busy  out  1  high in RUN or PAUSE
- done  out  1  high while in DONE
- wrap  out  1  one-cycle pulse on carry-out wrap (ACC_WRAP_EN only)
- run_cnt  out  4  completed runs, saturates at 15

## Operation
- Sum path: {Cout, S} = count + step through the adder, unsigned, 3-bit operands, 4-bit result.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: count = INIT; start -> RUN.
- RUN, pause=1: -> PAUSE, no add that cycle.
- RUN, pause=0: evaluate reached = (S >= limit) or Cout (carry term per Configuration).
  - reached: count <= limit, -> DONE, run_cnt += 1 (held at 15).
  - otherwise: count <= S.
- PAUSE: count holds; pause=0 -> RUN, no add that cycle.
- DONE: count holds at limit; start -> RUN with count <= INIT.
- start in RUN/PAUSE ignored. clear in any state: -> IDLE, count <= INIT, wrap <= 0; run_cnt is preserved.
- step=0: count holds; run terminates on the first active cycle if count >= limit.
- limit < INIT: run terminates on the first active cycle, count <= limit.

## Timing
- Reset values: count=INIT, busy=0, done=0, wrap=0, run_cnt=0, state IDLE.
- Reset is asynchronous; asserting it mid-run aborts immediately to reset values.
- start sampled at edge N -> busy=1 after N. First add at edge N+1 if pause=0.
- One add per active RUN cycle; count visible the cycle after the edge.
- done rises on the edge that loads limit; busy falls on the same edge.
- pause is sampled each edge; resume costs one cycle (PAUSE->RUN transition edge performs no add).
- Priority: reset > clear > start > pause.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- ACC_WRAP_EN defined: Cout does not end a run. count <= S (mod 8), wrap pulses for exactly one cycle, stay in RUN. reached = !Cout && S >= limit.
- ACC_WRAP_EN undefined: Cout counts as reached (clamp to limit, -> DONE). wrap tied to 0.

## Structure
- Package step_counter_pkg: state enum (IDLE, RUN, PAUSE, DONE), WIDTH=3, RUN_CNT_W=4, RUN_CNT_MAX=15.
- One sub-module: three_bit_adder instance (A=count, B=step). FSM, compare and registers live in step_counter_ctrl.

## Test plan
- Reset mid-run: count=3 in RUN, assert reset -> count=0, busy=0, done=0, run_cnt=0 immediately.
- step=2, limit=5: start -> count 0,2,4, then 5 with done=1, busy=0, run_cnt=1.
- step=3, limit=7: with ACC_WRAP_EN count 0,3,6,1 (wrap=1 for one cycle),4,7 and done. Without it: 0,3,6,7 and done, wrap stays 0.
- step=1, limit=6, pause high for 2 cycles at count=2 -> count holds at 2 with busy=1. After release, one idle cycle, then 3,4,5,6 and done.
- clear and start together in DONE -> IDLE, count=0, done=0, run_cnt unchanged. Sixteen full runs -> run_cnt stays at 15.
- step=0, limit=0: start -> done after the first active cycle, count=0.

Source files
------------

// File: rtl/step_counter_pkg.sv
// step_counter_pkg: shared widths, run-counter limits and FSM state encoding for step_counter_ctrl.
package step_counter_pkg;
    localparam int WIDTH       = 3;
    localparam int RUN_CNT_W   = 4;
    localparam int RUN_CNT_MAX = 15;
    localparam logic [WIDTH-1:0] INIT = '0;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/step_counter_ctrl_adder.sv
// three_bit_adder: unsigned ripple-carry adder, {cout, s} = a + b.
module three_bit_adder
    import step_counter_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[WIDTH];
endmodule

// File: rtl/step_counter_ctrl.sv
// step_counter_ctrl: run-controlled programmable-stride counter feeding three_bit_adder.
// Define ACC_WRAP_EN to let carry-out wrap the count (with a wrap pulse) instead of ending the run.
module step_counter_ctrl
    import step_counter_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 pause,
    input  logic [WIDTH-1:0]     step,
    input  logic [WIDTH-1:0]     limit,
    output logic [WIDTH-1:0]     count,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap,
    output logic [RUN_CNT_W-1:0] run_cnt
);
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     count_q, count_d, sum;
    logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic                 busy_q, busy_d, done_q, done_d, cout, reached;

    three_bit_adder u_adder (
        .a    (count_q),
        .b    (step),
        .s    (sum),
        .cout (cout)
    );

`ifdef ACC_WRAP_EN
    logic wrap_q, wrap_d;
    assign reached = !cout && sum >= limit;
    assign wrap    = wrap_q;
`else
    assign reached = cout || sum >= limit;
    assign wrap    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        run_cnt_d = run_cnt_q;
`ifdef ACC_WRAP_EN
        wrap_d    = 1'b0;
`endif
        if (clear) begin
            state_d = IDLE;
            count_d = INIT;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = INIT;
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (reached) begin
                        state_d   = DONE;
                        count_d   = limit;
                        run_cnt_d = (run_cnt_q == RUN_CNT_W'(RUN_CNT_MAX)) ? run_cnt_q : run_cnt_q + 1'b1;
                    end else begin
                        count_d = sum;
`ifdef ACC_WRAP_EN
                        wrap_d  = cout;
`endif
                    end
                end
                PAUSE: if (!pause) state_d = RUN;
                DONE: begin
                    if (start) begin
                        state_d = RUN;
                        count_d = INIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN) || (state_d == PAUSE);
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= INIT;
            run_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ACC_WRAP_EN
            wrap_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            run_cnt_q <= run_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef ACC_WRAP_EN
            wrap_q    <= wrap_d;
`endif
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign run_cnt = run_cnt_q;
endmodule

// File: tb/tb_step_counter_ctrl.sv
// tb_step_counter_ctrl: table-driven directed checks of step_counter_ctrl plus hand-written
// sequences for run-count saturation and asynchronous reset mid-run.
module tb_step_counter_ctrl;
    logic       clk = 1'b0, reset = 1'b1, clear = 1'b0, start = 1'b0, pause = 1'b0;
    logic [2:0] step = '0, limit = '0, count;
    logic       busy, done, wrap;
    logic [3:0] run_cnt;

    typedef struct {
        logic       clr, st, ps;
        logic [2:0] stp, lim, e_count;
        logic       e_busy, e_done, e_wrap;
        logic [3:0] e_runs;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0, fails = 0;

    step_counter_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .start   (start),
        .pause   (pause),
        .step    (step),
        .limit   (limit),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap),
        .run_cnt (run_cnt)
    );

    always #5 clk = ~clk;

    task automatic add(input logic clr, st, ps, input logic [2:0] stp, lim, cnt,
                       input logic b, d, w, input logic [3:0] r);
        vec_t v;
        v.clr = clr; v.st = st; v.ps = ps; v.stp = stp; v.lim = lim;
        v.e_count = cnt; v.e_busy = b; v.e_done = d; v.e_wrap = w; v.e_runs = r;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] cnt, input logic b, d, w,
                         input logic [3:0] r);
        tests++;
        if ({count, busy, done, wrap, run_cnt} !== {cnt, b, d, w, r}) begin
            fails++;
            $display("FAIL %s: got count=%0d busy=%b done=%b wrap=%b run_cnt=%0d, expected count=%0d busy=%b done=%b wrap=%b run_cnt=%0d",
                     name, count, busy, done, wrap, run_cnt, cnt, b, d, w, r);
        end
    endtask

    task automatic drive(input logic clr, st, ps, input logic [2:0] stp, lim);
        @(negedge clk);
        clear = clr; start = st; pause = ps; step = stp; limit = lim;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // step=2 limit=5
        add(0,1,0,2,5, 0,1,0,0,1'd0);
        add(0,0,0,2,5, 2,1,0,0,0);
        add(0,0,0,2,5, 4,1,0,0,0);
        add(0,0,0,2,5, 5,0,1,0,1);
        add(0,0,0,2,5, 5,0,1,0,1);
        // step=3 limit=7, carry behaviour
        add(0,1,0,3,7, 0,1,0,0,1);
        add(0,0,0,3,7, 3,1,0,0,1);
        add(0,0,0,3,7, 6,1,0,0,1);
`ifdef ACC_WRAP_EN
        add(0,0,0,3,7, 1,1,0,1,1);
        add(0,0,0,3,7, 4,1,0,0,1);
        add(0,0,0,3,7, 7,0,1,0,2);
`else
        add(0,0,0,3,7, 7,0,1,0,2);
        add(0,0,0,3,7, 7,0,1,0,2);
`endif
        // step=1 limit=6 with a two-cycle pause at count=2
        add(0,1,0,1,6, 0,1,0,0,2);
        add(0,0,0,1,6, 1,1,0,0,2);
        add(0,0,0,1,6, 2,1,0,0,2);
        add(0,0,1,1,6, 2,1,0,0,2);
        add(0,0,1,1,6, 2,1,0,0,2);
        add(0,0,0,1,6, 2,1,0,0,2);
        add(0,0,0,1,6, 3,1,0,0,2);
        add(0,0,0,1,6, 4,1,0,0,2);
        add(0,0,0,1,6, 5,1,0,0,2);
        add(0,0,0,1,6, 6,0,1,0,3);
        // clear beats start in DONE; start ignored in RUN; clear mid-run
        add(1,1,0,1,6, 0,0,0,0,3);
        add(0,1,0,1,6, 0,1,0,0,3);
        add(0,1,0,1,6, 1,1,0,0,3);
        add(1,0,0,1,6, 0,0,0,0,3);
        // step=0 limit=0 terminates on the first active cycle
        add(0,1,0,0,0, 0,1,0,0,3);
        add(0,0,0,0,0, 0,0,1,0,4);

        repeat (2) @(negedge clk);
        check("reset_values", 0, 0, 0, 0, 0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].clr, vecs[k].st, vecs[k].ps, vecs[k].stp, vecs[k].lim);
            check($sformatf("vec%0d", k), vecs[k].e_count, vecs[k].e_busy, vecs[k].e_done,
                  vecs[k].e_wrap, vecs[k].e_runs);
        end

        // run_cnt saturation: 13 more one-step runs from run_cnt=4
        for (int k = 1; k <= 13; k++) begin
            logic [3:0] exp_runs;
            exp_runs = (4 + k > 15) ? 4'd15 : 4'(4 + k);
            drive(0, 1, 0, 7, 7);
            check($sformatf("sat_start%0d", k), 0, 1, 0, 0, 4'((4 + k - 1 > 15) ? 15 : 4 + k - 1));
            drive(0, 0, 0, 7, 7);
            check($sformatf("sat_done%0d", k), 7, 0, 1, 0, exp_runs);
        end
        drive(1, 0, 0, 7, 7);
        check("clear_keeps_runs", 0, 0, 0, 0, 15);

        // asynchronous reset in the middle of a run at count=3
        drive(0, 1, 0, 1, 6);
        for (int k = 1; k <= 3; k++) drive(0, 0, 0, 1, 6);
        check("pre_reset_count3", 3, 1, 0, 0, 15);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 1, 6);
        check("after_reset_idle", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
